// File: rtl/rv32i_types.sv
// Shared types for the dual-port memory responder: per-port FSM state,
// latched request bundle and byte-lane helpers.
package rv32i_types;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } port_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } mem_req_t;

   function automatic logic [31:0] byte_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   function automatic logic [31:0] byte_merge(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input logic [3:0]  m
   );
      return (old_w & ~byte_mask(m)) | (new_w & byte_mask(m));
   endfunction

endpackage

// File: rtl/dual_port_mem_responder_if.sv
// Fetch and load/store request/response bundle between a core and the
// dual-port memory responder.
interface dual_port_mem_responder_if;

   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;

   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;

   logic        err;

   modport master (
      output imem_addr,
      output imem_rmask,
      input  imem_rdata,
      input  imem_resp,
      output dmem_addr,
      output dmem_rmask,
      output dmem_wmask,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_resp,
      input  err
   );

   modport slave (
      input  imem_addr,
      input  imem_rmask,
      output imem_rdata,
      output imem_resp,
      input  dmem_addr,
      input  dmem_rmask,
      input  dmem_wmask,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_resp,
      output err
   );

endinterface

// File: rtl/mem_port_ctrl.sv
// One request port: IDLE/WAIT/RESP sequencing with a latency countdown,
// request latching and detection of requests that change while in flight.
module mem_port_ctrl
   import rv32i_types::*;
#(
   parameter int unsigned LATENCY = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  mem_req_t req,
   output mem_req_t act,
   output logic     sample,
   output logic     enter_resp,
   output logic     mismatch,
   output logic     resp
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   port_state_t state;
   logic [3:0]  cnt;
   mem_req_t    lat;
   logic        present;

   assign present = |{req.rmask, req.wmask};
   assign sample  = (state == ST_IDLE) && present;

   // In IDLE the live request is the one about to be latched.
   assign act      = (state == ST_IDLE) ? req : lat;
   assign mismatch = (state != ST_IDLE) && (req != lat);

   assign enter_resp = !rst &&
                       ((sample && (LATENCY == 1)) ||
                        ((state == ST_WAIT) && (cnt <= 4'd1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         lat   <= '0;
         resp  <= 1'b0;
      end else begin
         resp <= enter_resp;
         unique case (state)
            ST_IDLE: begin
               if (present) begin
                  lat <= req;
                  if (LATENCY == 1) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt <= 4'd1) begin
                  state <= ST_RESP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dual_port_mem_responder.sv
// Word-addressed memory with independent fetch and load/store ports,
// fixed response latency, write-first fetch bypass and sticky error flag.
module dual_port_mem_responder
   import rv32i_types::*;
#(
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1ECEB000
) (
   input logic clk,
   input logic rst,
   dual_port_mem_responder_if.slave bus
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   function automatic logic addr_ok(input logic [31:0] a);
      logic [32:0] off;
      off = {1'b0, a - BASE_ADDR};
      return off < SPAN;
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return off[AW+1:2];
   endfunction

   function automatic logic req_bad(input mem_req_t r);
      return !addr_ok(r.addr) ||
             (r.addr[1:0] != 2'b00) ||
             ((r.rmask != 4'h0) && (r.wmask != 4'h0));
   endfunction

   logic [31:0] mem [DEPTH_WORDS];

   mem_req_t i_req;
   mem_req_t d_req;
   mem_req_t i_act;
   mem_req_t d_act;
   logic     i_sample;
   logic     d_sample;
   logic     i_enter;
   logic     d_enter;
   logic     i_mis;
   logic     d_mis;
   logic     i_unused;

   assign i_req = '{
      addr:  bus.imem_addr,
      rmask: bus.imem_rmask,
      wmask: 4'h0,
      wdata: 32'h0
   };

   assign d_req = '{
      addr:  bus.dmem_addr,
      rmask: bus.dmem_rmask,
      wmask: bus.dmem_wmask,
      wdata: bus.dmem_wdata
   };

   assign i_unused = ^i_act.wdata;

   mem_port_ctrl #(
      .LATENCY (LATENCY)
   ) u_iport (
      .clk        (clk),
      .rst        (rst),
      .req        (i_req),
      .act        (i_act),
      .sample     (i_sample),
      .enter_resp (i_enter),
      .mismatch   (i_mis),
      .resp       (bus.imem_resp)
   );

   mem_port_ctrl #(
      .LATENCY (LATENCY)
   ) u_dport (
      .clk        (clk),
      .rst        (rst),
      .req        (d_req),
      .act        (d_act),
      .sample     (d_sample),
      .enter_resp (d_enter),
      .mismatch   (d_mis),
      .resp       (bus.dmem_resp)
   );

   logic          i_ok;
   logic          d_ok;
   logic          d_wr;
   logic          i_bad;
   logic          d_bad;
   logic [AW-1:0] i_idx;
   logic [AW-1:0] d_idx;
   logic [31:0]   d_new;
   logic [31:0]   i_word;

   assign i_ok  = addr_ok(i_act.addr);
   assign d_ok  = addr_ok(d_act.addr);
   assign i_idx = word_idx(i_act.addr);
   assign d_idx = word_idx(d_act.addr);

   // A write wins over a simultaneous read on the same request.
   assign d_wr  = d_ok && (d_act.wmask != 4'h0);
   assign d_new = byte_merge(mem[d_idx], d_act.wdata, d_act.wmask);

   assign i_bad = i_sample && req_bad(i_act);
   assign d_bad = d_sample && req_bad(d_act);

   always_comb begin
      i_word = mem[i_idx];
      if (d_enter && d_wr && (d_idx == i_idx)) begin
         i_word = d_new;
      end
   end

   always_ff @(posedge clk) begin
      if (d_enter && d_wr) begin
         mem[d_idx] <= d_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.imem_rdata <= '0;
         bus.dmem_rdata <= '0;
         bus.err        <= 1'b0;
      end else begin
         if (i_enter && i_ok) begin
            bus.imem_rdata <= i_word & byte_mask(i_act.rmask);
         end else begin
            bus.imem_rdata <= '0;
         end
         if (d_enter && d_ok && (d_act.wmask == 4'h0)) begin
            bus.dmem_rdata <= mem[d_idx] & byte_mask(d_act.rmask);
         end else begin
            bus.dmem_rdata <= '0;
         end
         if (i_bad || d_bad || i_mis || d_mis) begin
            bus.err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench: directed vector table, randomized traffic against a
// word-array model, and hand sequences for error, reset and LATENCY=1 cases.
module tb_dual_port_mem_responder;

   localparam logic [31:0] BASE = 32'h1ECEB000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   dual_port_mem_responder_if bus2 ();
   dual_port_mem_responder_if bus1 ();

   dual_port_mem_responder #(
      .LATENCY (2)
   ) u2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   dual_port_mem_responder #(
      .LATENCY (1)
   ) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [16];

   typedef struct {
      logic        ie;
      logic [31:0] ia;
      logic [3:0]  irm;
      logic        de;
      logic [31:0] da;
      logic [3:0]  drm;
      logic [3:0]  dwm;
      logic [31:0] dwd;
      logic [31:0] ei;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [11];

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = m[b] ? 8'hFF : 8'h00;
      end
      return r;
   endfunction

   task automatic chk(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_bus();
      bus2.imem_addr  = '0;
      bus2.imem_rmask = '0;
      bus2.dmem_addr  = '0;
      bus2.dmem_rmask = '0;
      bus2.dmem_wmask = '0;
      bus2.dmem_wdata = '0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run(
      input  logic        ie,
      input  logic [31:0] ia,
      input  logic [3:0]  irm,
      input  logic        de,
      input  logic [31:0] da,
      input  logic [3:0]  drm,
      input  logic [3:0]  dwm,
      input  logic [31:0] dwd,
      output logic [31:0] ird,
      output logic [31:0] drd,
      output int          icyc,
      output int          dcyc
   );
      logic idone;
      logic ddone;
      idone = !ie;
      ddone = !de;
      ird   = '0;
      drd   = '0;
      icyc  = 0;
      dcyc  = 0;
      bus2.imem_addr  = ia;
      bus2.imem_rmask = ie ? irm : 4'h0;
      bus2.dmem_addr  = da;
      bus2.dmem_rmask = de ? drm : 4'h0;
      bus2.dmem_wmask = de ? dwm : 4'h0;
      bus2.dmem_wdata = dwd;
      for (int k = 1; k <= 30 && !(idone && ddone); k++) begin
         @(posedge clk);
         #1;
         if (bus2.imem_resp && !idone) begin
            ird   = bus2.imem_rdata;
            icyc  = k;
            idone = 1'b1;
         end
         if (bus2.dmem_resp && !ddone) begin
            drd   = bus2.dmem_rdata;
            dcyc  = k;
            ddone = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("resp_one_cycle",
          {30'd0, bus2.imem_resp, bus2.dmem_resp}, 32'd0);
      chk("rdata_zero_idle",
          bus2.imem_rdata | bus2.dmem_rdata, 32'd0);
      idle_bus();
   endtask

   logic [31:0] ird;
   logic [31:0] drd;
   int          icyc;
   int          dcyc;
   logic [31:0] exp_i;
   logic [31:0] exp_d;
   int          iw;
   int          dw;
   logic        ie;
   logic        de;
   logic        wr;
   logic [3:0]  irm;
   logic [3:0]  drm;
   logic [3:0]  dwm;
   logic [31:0] dwd;
   int          pulses;
   logic [5:0]  pat;

   initial begin
      tbl[0]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE, 4'h0, 4'hF,
                  32'h0BADF00D, 32'h0, 32'h0};
      tbl[1]  = '{1'b1, BASE, 4'hF, 1'b0, 32'h0, 4'h0, 4'h0,
                  32'h0, 32'h0BADF00D, 32'h0};
      tbl[2]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE + 4, 4'h0, 4'hF,
                  32'h11223344, 32'h0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE + 4, 4'h0, 4'b0011,
                  32'hAABBCCDD, 32'h0, 32'h0};
      tbl[4]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE + 4, 4'hF, 4'h0,
                  32'h0, 32'h0, 32'h1122CCDD};
      tbl[5]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE + 4, 4'b1100, 4'h0,
                  32'h0, 32'h0, 32'h11220000};
      tbl[6]  = '{1'b1, BASE + 8, 4'hF, 1'b1, BASE + 8, 4'h0, 4'hF,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
      tbl[7]  = '{1'b1, BASE + 8, 4'b0101, 1'b0, 32'h0, 4'h0, 4'h0,
                  32'h0, 32'h00AD00EF, 32'h0};
      tbl[8]  = '{1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'hFFC, 4'h0, 4'hF,
                  32'h5A5A5A5A, 32'h0, 32'h0};
      tbl[9]  = '{1'b1, BASE + 32'hFFC, 4'b1001, 1'b0, 32'h0, 4'h0, 4'h0,
                  32'h0, 32'h5A00005A, 32'h0};
      tbl[10] = '{1'b1, BASE + 4, 4'hF, 1'b1, BASE + 4, 4'h0, 4'b1000,
                  32'h77000000, 32'h7722CCDD, 32'h0};

      idle_bus();
      bus1.imem_addr  = '0;
      bus1.imem_rmask = '0;
      bus1.dmem_addr  = '0;
      bus1.dmem_rmask = '0;
      bus1.dmem_wmask = '0;
      bus1.dmem_wdata = '0;

      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs",
          {29'd0, bus2.imem_resp, bus2.dmem_resp, bus2.err}, 32'd0);
      chk("reset_rdata", bus2.imem_rdata | bus2.dmem_rdata, 32'd0);
      rst = 1'b0;

      foreach (tbl[v]) begin
         run(tbl[v].ie, tbl[v].ia, tbl[v].irm,
             tbl[v].de, tbl[v].da, tbl[v].drm, tbl[v].dwm, tbl[v].dwd,
             ird, drd, icyc, dcyc);
         if (tbl[v].ie) begin
            chk("vec_idata", ird, tbl[v].ei);
            chk("vec_ilat", 32'(icyc), 32'd2);
         end
         if (tbl[v].de) begin
            chk("vec_ddata", drd, tbl[v].ed);
            chk("vec_dlat", 32'(dcyc), 32'd2);
         end
         chk("vec_err", 32'(bus2.err), 32'd0);
      end

      for (int w = 0; w < 16; w++) begin
         ref_mem[w] = $urandom;
         run(1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'(4 * w), 4'h0, 4'hF,
             ref_mem[w], ird, drd, icyc, dcyc);
      end

      for (int n = 0; n < 40; n++) begin
         iw  = int'($urandom_range(0, 15));
         dw  = int'($urandom_range(0, 15));
         ie  = 1'($urandom_range(0, 1));
         de  = ie ? 1'($urandom_range(0, 1)) : 1'b1;
         wr  = 1'($urandom_range(0, 1));
         irm = 4'($urandom_range(1, 15));
         drm = wr ? 4'h0 : 4'($urandom_range(1, 15));
         dwm = wr ? 4'($urandom_range(1, 15)) : 4'h0;
         dwd = $urandom;
         exp_d = wr ? 32'h0 : (ref_mem[dw] & lanes(drm));
         if (de && wr) begin
            ref_mem[dw] = (ref_mem[dw] & ~lanes(dwm)) | (dwd & lanes(dwm));
         end
         exp_i = ref_mem[iw] & lanes(irm);
         run(ie, BASE + 32'(4 * iw), irm, de, BASE + 32'(4 * dw),
             drm, dwm, dwd, ird, drd, icyc, dcyc);
         if (ie) begin
            chk("rand_idata", ird, exp_i);
            chk("rand_ilat", 32'(icyc), 32'd2);
         end
         if (de) begin
            chk("rand_ddata", drd, exp_d);
            chk("rand_dlat", 32'(dcyc), 32'd2);
         end
      end
      chk("rand_err", 32'(bus2.err), 32'd0);

      run(1'b0, 32'h0, 4'h0, 1'b1, 32'h00000010, 4'hF, 4'h0, 32'h0,
          ird, drd, icyc, dcyc);
      chk("oob_rdata", drd, 32'h0);
      chk("oob_lat", 32'(dcyc), 32'd2);
      chk("oob_err", 32'(bus2.err), 32'd1);

      run(1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h1000, 4'h0, 4'hF,
          32'hFFFFFFFF, ird, drd, icyc, dcyc);
      chk("oob_store_lat", 32'(dcyc), 32'd2);
      run(1'b0, 32'h0, 4'h0, 1'b1, BASE, 4'hF, 4'h0, 32'h0,
          ird, drd, icyc, dcyc);
      chk("oob_store_suppressed", drd, ref_mem[0]);
      chk("err_sticky", 32'(bus2.err), 32'd1);

      bus2.dmem_addr  = BASE + 8;
      bus2.dmem_wmask = 4'hF;
      bus2.dmem_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      chk("rst_pre_resp", 32'(bus2.dmem_resp), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_async_err", 32'(bus2.err), 32'd0);
      chk("rst_async_outs",
          bus2.imem_rdata | bus2.dmem_rdata |
          {30'd0, bus2.imem_resp, bus2.dmem_resp}, 32'd0);
      pulses = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus2.dmem_resp) pulses++;
      end
      chk("rst_no_resp", 32'(pulses), 32'd0);
      idle_bus();
      rst = 1'b0;
      run(1'b0, 32'h0, 4'h0, 1'b1, BASE + 8, 4'hF, 4'h0, 32'h0,
          ird, drd, icyc, dcyc);
      chk("rst_word_kept", drd, ref_mem[2]);
      chk("rst_err_clear", 32'(bus2.err), 32'd0);

      bus2.imem_addr  = BASE + 12;
      bus2.imem_rmask = 4'hF;
      @(posedge clk);
      #1;
      chk("mis_pre_err", 32'(bus2.err), 32'd0);
      bus2.imem_addr = BASE + 16;
      @(posedge clk);
      #1;
      chk("mis_resp", 32'(bus2.imem_resp), 32'd1);
      chk("mis_latched_data", bus2.imem_rdata, ref_mem[3]);
      chk("mis_err", 32'(bus2.err), 32'd1);
      @(posedge clk);
      #1;
      idle_bus();
      pulse_rst();

      run(1'b0, 32'h0, 4'h0, 1'b1, BASE + 4, 4'hF, 4'hF, 32'h600DCAFE,
          ird, drd, icyc, dcyc);
      ref_mem[1] = 32'h600DCAFE;
      chk("rw_rdata", drd, 32'h0);
      chk("rw_err", 32'(bus2.err), 32'd1);
      pulse_rst();
      run(1'b1, BASE + 5, 4'hF, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0,
          ird, drd, icyc, dcyc);
      chk("misalign_data", ird, ref_mem[1]);
      chk("misalign_lat", 32'(icyc), 32'd2);
      chk("misalign_err", 32'(bus2.err), 32'd1);
      pulse_rst();

      bus1.dmem_addr  = BASE;
      bus1.dmem_wmask = 4'hF;
      bus1.dmem_wdata = 32'hCAFEF00D;
      pat = '0;
      repeat (6) begin
         @(posedge clk);
         #1;
         pat = {pat[4:0], bus1.dmem_resp};
      end
      bus1.dmem_wmask = 4'h0;
      chk("l1_store_pattern", 32'(pat), 32'b101010);
      bus1.imem_addr  = BASE;
      bus1.imem_rmask = 4'hF;
      pat = '0;
      exp_i = '0;
      repeat (4) begin
         @(posedge clk);
         #1;
         pat = {pat[4:0], bus1.imem_resp};
         exp_i = exp_i | bus1.imem_rdata;
      end
      bus1.imem_rmask = 4'h0;
      chk("l1_load_pattern", 32'(pat), 32'b001010);
      chk("l1_load_data", exp_i, 32'hCAFEF00D);
      chk("l1_err_clean", 32'(bus1.err), 32'd0);
      bus1.imem_rmask = 4'hF;
      @(posedge clk);
      #1;
      bus1.imem_addr = BASE + 4;
      @(posedge clk);
      #1;
      bus1.imem_rmask = 4'h0;
      chk("l1_mismatch_err", 32'(bus1.err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_port_mem_responder.md
DUAL_PORT_MEM_RESPONDER -- requirements
Module: dual_port_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, cycles from request sample to resp (legal range 1-15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array (power of two).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1ECEB000, byte address of word 0.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports imem_addr  input  32  fetch byte address; imem_rmask  input  4  fetch byte-read mask.
REQ-007 The block SHALL have ports imem_rdata  output  32  fetch data; imem_resp  output  1  fetch completion pulse.
REQ-008 The block SHALL have ports dmem_addr  input  32; dmem_rmask  input  4; dmem_wmask  input  4; dmem_wdata  input  32  load/store request.
REQ-009 The block SHALL have ports dmem_rdata  output  32  load data; dmem_resp  output  1  load/store completion pulse.
REQ-010 The block SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-011 Each port SHALL run an independent FSM: IDLE, WAIT, RESP.
REQ-012 A request SHALL be present when its port's rmask|wmask is nonzero; in IDLE it is sampled (addr, masks, wdata latched) at the rising edge.
REQ-013 After sampling, the FSM SHALL go to WAIT with a countdown loaded to LATENCY-1, or directly to RESP when LATENCY=1.
REQ-014 In WAIT the counter SHALL decrement each cycle; at zero the FSM enters RESP, so resp is high exactly LATENCY cycles after the sample edge.
REQ-015 resp SHALL be high for exactly one cycle, in RESP only; the FSM returns to IDLE on the next edge and ignores requests present during the RESP cycle.
REQ-016 The requester holds the request stable until resp; mismatch between inputs and latched request during WAIT/RESP SHALL set err, with the latched request used.
REQ-017 Read data SHALL be registered from the array at the edge entering RESP, with unmasked bytes driven 0; rdata is 0 whenever resp is low.
REQ-018 A dmem write SHALL commit masked bytes of dmem_wdata at the edge entering RESP.
REQ-019 If an imem read and a dmem write to the same word both enter RESP on the same edge, imem_rdata SHALL reflect the newly written bytes (write-first).
REQ-020 Word index SHALL be (addr-BASE_ADDR)>>2, modulo DEPTH_WORDS; address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL set err, still respond, return rdata 0, and suppress the write.
REQ-021 Nonzero dmem_rmask and dmem_wmask together, or addr[1:0] nonzero, SHALL set err; the request is still completed, with the write taking priority.
REQ-022 Once set, err SHALL remain high until reset.

Reset
REQ-023 On rst, both FSMs SHALL go to IDLE, counters to 0, imem_resp/dmem_resp/err to 0, and imem_rdata/dmem_rdata to 0, immediately and asynchronously.
REQ-024 Reset mid-operation SHALL discard outstanding requests without committing pending writes; array contents SHALL be retained (not cleared).
REQ-025 The first request SHALL be sampled at the first rising edge with rst low.

Structure
REQ-026 The FSM state enum and the latched request struct (addr, rmask, wmask, wdata) SHALL live in the shared rv32i_types package.
REQ-027 The per-port FSM/counter SHALL be one sub-module, mem_port_ctrl, instantiated twice (imem with wmask tied 0); the array and write-first bypass stay in the top.

Verification
REQ-028 LATENCY=2, imem read 0x1ECEB000 rmask 4'hF held -> imem_resp high exactly 2 cycles after sample, single cycle, rdata = word 0.
REQ-029 dmem store 0x1ECEB004 wmask 4'b0011 wdata 32'hAABBCCDD over word 32'h11223344, then load rmask 4'hF -> load returns 32'h1122CCDD.
REQ-030 Same-cycle imem read and dmem store, both targeting 0x1ECEB008 with wdata 32'hDEADBEEF -> imem_rdata = 32'hDEADBEEF.
REQ-031 dmem load at 0x00000010 -> dmem_resp after LATENCY, rdata 0, err high and sticky.
REQ-032 Store issued, rst asserted in WAIT -> resp never pulses, word unchanged, all outputs 0 immediately.
REQ-033 Back-to-back requests, LATENCY=1 -> resp every other cycle; a request changed during WAIT sets err.
